// File: rtl/jelly_reverse_addr_gen.sv
// Frame address sequencer: streams 2^N linear or bit-reversed addresses over valid/ready.
// States: S_IDLE = waiting for start | S_RUN = presenting beats of the current frame.
module jelly_reverse_addr_gen #(
    parameter int ADDR_WIDTH = 10,
    parameter int SIZE_WIDTH = 4
) (
    input  logic                  aresetn,
    input  logic                  aclk,
    input  logic                  start,
    input  logic                  abort,
    input  logic [SIZE_WIDTH-1:0] log2_size,
    input  logic                  reverse,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] m_index,
    output logic [ADDR_WIDTH-1:0] m_addr,
    output logic                  m_last,
    output logic                  m_valid,
    input  logic                  m_ready
);

    localparam int NW = $clog2(ADDR_WIDTH + 1);

    typedef enum logic [0:0] {S_IDLE, S_RUN} state_t;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
    logic [NW-1:0]         n_q, n_d;
    logic                  rev_q, rev_d;
    logic                  done_q, done_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  last_q, last_d;
    logic [ADDR_WIDTH:0]   last_idx;
    logic [ADDR_WIDTH:0]   one;

    // Reversing all ADDR_WIDTH bits then shifting down leaves index bits [N-1:0] mirrored.
    function automatic logic [ADDR_WIDTH-1:0] rev_addr(input logic [ADDR_WIDTH-1:0] idx,
                                                       input logic [NW-1:0] n);
        logic [ADDR_WIDTH-1:0] full;
        for (int i = 0; i < ADDR_WIDTH; i++) begin
            full[i] = idx[ADDR_WIDTH-1-i];
        end
        return full >> (NW'(ADDR_WIDTH) - n);
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        n_d      = n_q;
        rev_d    = rev_q;
        done_d   = 1'b0;
        one      = '0;
        one[0]   = 1'b1;
        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    state_d = S_RUN;
                    cnt_d   = '0;
                    rev_d   = reverse;
                    if (32'(log2_size) > ADDR_WIDTH) n_d = NW'(ADDR_WIDTH);
                    else                             n_d = NW'(log2_size);
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (m_ready) begin
                    if (last_q) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        done_d  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + one;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        last_idx = (one << n_d) - one;
        addr_d   = rev_d ? rev_addr(cnt_d[ADDR_WIDTH-1:0], n_d) : cnt_d[ADDR_WIDTH-1:0];
        last_d   = (state_d == S_RUN) && (cnt_d == last_idx);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            n_q     <= '0;
            rev_q   <= 1'b0;
            done_q  <= 1'b0;
            addr_q  <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            n_q     <= n_d;
            rev_q   <= rev_d;
            done_q  <= done_d;
            addr_q  <= addr_d;
            last_q  <= last_d;
        end
    end

    assign busy    = (state_q == S_RUN);
    assign m_valid = (state_q == S_RUN);
    assign done    = done_q;
    assign m_index = cnt_q[ADDR_WIDTH-1:0];
    assign m_addr  = addr_q;
    assign m_last  = last_q;

endmodule

// File: tb/tb_jelly_reverse_addr_gen.sv
// Directed bench for jelly_reverse_addr_gen: probe table plus multi-cycle corner sequences.
module tb_jelly_reverse_addr_gen;

    logic       aresetn, aclk, start, abort, reverse, m_ready;
    logic [3:0] log2_size;
    logic       busy, done, m_last, m_valid;
    logic [9:0] m_index, m_addr;

    int checks = 0;
    int errors = 0;

    jelly_reverse_addr_gen #(.ADDR_WIDTH(10), .SIZE_WIDTH(4)) dut (
        .aresetn(aresetn), .aclk(aclk), .start(start), .abort(abort),
        .log2_size(log2_size), .reverse(reverse), .busy(busy), .done(done),
        .m_index(m_index), .m_addr(m_addr), .m_last(m_last), .m_valid(m_valid),
        .m_ready(m_ready)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    typedef struct {
        int ls;
        int rev;
        int beat;
        int addr;
        int last;
    } vec_t;

    vec_t vecs[14];

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic start_frame(input int ls, input int rev);
        start = 1'b1;
        log2_size = 4'(ls);
        reverse = rev[0];
        tick();
        start = 1'b0;
    endtask

    task automatic check_idle_zero(input string tag);
        check({tag, "_busy"}, int'(busy), 0);
        check({tag, "_valid"}, int'(m_valid), 0);
        check({tag, "_done"}, int'(done), 0);
        check({tag, "_last"}, int'(m_last), 0);
        check({tag, "_index"}, int'(m_index), 0);
        check({tag, "_addr"}, int'(m_addr), 0);
    endtask

    initial begin
        int exp_addr[8];
        int exp_cnt;
        int cyc;
        bit rdy;

        vecs[0]  = '{3, 1, 0, 0, 0};
        vecs[1]  = '{3, 1, 1, 4, 0};
        vecs[2]  = '{3, 1, 3, 6, 0};
        vecs[3]  = '{3, 1, 7, 7, 1};
        vecs[4]  = '{3, 0, 5, 5, 0};
        vecs[5]  = '{0, 1, 0, 0, 1};
        vecs[6]  = '{0, 0, 0, 0, 1};
        vecs[7]  = '{15, 1, 1, 512, 0};
        vecs[8]  = '{15, 1, 1023, 1023, 1};
        vecs[9]  = '{4, 1, 1, 8, 0};
        vecs[10] = '{4, 1, 3, 12, 0};
        vecs[11] = '{10, 1, 6, 384, 0};
        vecs[12] = '{2, 1, 2, 1, 0};
        vecs[13] = '{5, 0, 31, 31, 1};
        exp_addr = '{0, 4, 2, 6, 1, 5, 3, 7};

        aresetn = 1'b0; start = 1'b0; abort = 1'b0; reverse = 1'b0;
        m_ready = 1'b0; log2_size = '0;
        tick(); tick();
        check_idle_zero("reset");
        aresetn = 1'b1;
        tick();

        // Probe table: run to a beat, freeze with ready low, check, abort.
        for (int v = 0; v < 14; v++) begin
            start_frame(vecs[v].ls, vecs[v].rev);
            m_ready = 1'b1;
            repeat (vecs[v].beat) tick();
            m_ready = 1'b0;
            check($sformatf("vec%0d_valid", v), int'(m_valid), 1);
            check($sformatf("vec%0d_index", v), int'(m_index), vecs[v].beat);
            check($sformatf("vec%0d_addr", v), int'(m_addr), vecs[v].addr);
            check($sformatf("vec%0d_last", v), int'(m_last), vecs[v].last);
            abort = 1'b1;
            tick();
            abort = 1'b0;
            check($sformatf("vec%0d_abort_busy", v), int'(busy), 0);
            check($sformatf("vec%0d_abort_done", v), int'(done), 0);
        end

        // Full reversed N=3 frame, with start/mode/size toggled mid-frame.
        start_frame(3, 1);
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if (i == 3) begin start = 1'b1; reverse = 1'b0; log2_size = 4'd2; end
            if (i == 5) begin start = 1'b0; reverse = 1'b1; log2_size = 4'd9; end
            check($sformatf("rev_valid%0d", i), int'(m_valid), 1);
            check($sformatf("rev_addr%0d", i), int'(m_addr), exp_addr[i]);
            check($sformatf("rev_last%0d", i), int'(m_last), (i == 7) ? 1 : 0);
            check($sformatf("rev_done%0d", i), int'(done), 0);
            tick();
        end
        check("rev_done", int'(done), 1);
        check("rev_end_busy", int'(busy), 0);
        check("rev_end_valid", int'(m_valid), 0);
        check("rev_end_last", int'(m_last), 0);

        // Start in the done cycle: next beat 0 two cycles after the last beat.
        start = 1'b1; log2_size = 4'd1; reverse = 1'b0;
        tick();
        start = 1'b0;
        check("b2b_done_clr", int'(done), 0);
        check("b2b_valid", int'(m_valid), 1);
        check("b2b_index0", int'(m_index), 0);
        check("b2b_last0", int'(m_last), 0);
        tick();
        check("b2b_index1", int'(m_index), 1);
        check("b2b_last1", int'(m_last), 1);
        tick();
        check("b2b_done", int'(done), 1);

        // Linear N=3 with random stalls; outputs must track the beat count.
        m_ready = 1'b0;
        start_frame(3, 0);
        exp_cnt = 0;
        cyc = 0;
        while (exp_cnt < 8 && cyc < 300) begin
            check("stall_valid", int'(m_valid), 1);
            check("stall_index", int'(m_index), exp_cnt);
            check("stall_addr", int'(m_addr), exp_cnt);
            check("stall_last", int'(m_last), (exp_cnt == 7) ? 1 : 0);
            check("stall_done", int'(done), 0);
            rdy = 1'($urandom_range(0, 1));
            m_ready = rdy;
            tick();
            if (rdy) exp_cnt++;
            cyc++;
        end
        check("stall_beats", exp_cnt, 8);
        check("stall_done_end", int'(done), 1);
        check("stall_busy_end", int'(busy), 0);
        m_ready = 1'b0;

        // Abort at beat 3 of an N=4 frame.
        start_frame(4, 1);
        m_ready = 1'b1;
        repeat (3) tick();
        check("ab3_index", int'(m_index), 3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("ab3_valid", int'(m_valid), 0);
        check("ab3_busy", int'(busy), 0);
        check("ab3_done", int'(done), 0);
        tick();
        check("ab3_done_late", int'(done), 0);
        check("ab3_still_idle", int'(busy), 0);

        // Abort coincident with the final transfer.
        start_frame(1, 0);
        tick();
        check("abl_last", int'(m_last), 1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abl_done", int'(done), 0);
        check("abl_valid", int'(m_valid), 0);
        tick();
        check("abl_done_late", int'(done), 0);

        // Abort in idle does nothing; a following start still works.
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("abidle_busy", int'(busy), 0);

        // Asynchronous reset mid-frame.
        start_frame(3, 1);
        tick(); tick();
        check("rst_pre_addr", int'(m_addr), 2);
        #1 aresetn = 1'b0;
        #1;
        check_idle_zero("rst_async");
        tick();
        aresetn = 1'b1;
        tick();
        check("rst_after_busy", int'(busy), 0);
        start_frame(3, 1);
        check("rst_new_valid", int'(m_valid), 1);
        check("rst_new_addr0", int'(m_addr), 0);
        tick();
        check("rst_new_addr1", int'(m_addr), 4);
        m_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
